// File: rtl/bus_pkg.sv
// Shared constants for the CPU datapath bus: widths and source indices.
package bus_pkg;

  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 27;

  // Source indices, also the priority order (lower index wins).
  localparam logic [4:0] SRC_R0    = 5'd0;
  localparam logic [4:0] SRC_R15   = 5'd15;
  localparam logic [4:0] SRC_HI    = 5'd16;
  localparam logic [4:0] SRC_LO    = 5'd17;
  localparam logic [4:0] SRC_ZHI   = 5'd18;
  localparam logic [4:0] SRC_ZLO   = 5'd19;
  localparam logic [4:0] SRC_PC    = 5'd20;
  localparam logic [4:0] SRC_IR    = 5'd21;
  localparam logic [4:0] SRC_MDR   = 5'd22;
  localparam logic [4:0] SRC_IN    = 5'd23;
  localparam logic [4:0] SRC_CSIGN = 5'd24;
  localparam logic [4:0] SRC_Y     = 5'd25;
  localparam logic [4:0] SRC_MAR   = 5'd26;

  // Encoded value meaning "nothing drives the bus".
  localparam logic [4:0] SRC_NONE  = 5'd31;

endpackage

// File: rtl/bus_encoder_32to5.sv
// Priority encoder: 27 source enables -> lowest asserted index, plus a
// flag raised when more than one enable is active.
module bus_encoder_32to5
  import bus_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_en,
  output logic [4:0]         o_sel,
  output logic               o_multi
);

  // Scan from the lowest-priority source upward so the lowest index wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_sel = SRC_NONE;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_en[i]) o_sel = 5'(i);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign o_multi = |(i_en & (i_en - {{(NUM_SRC-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/datapath_bus.sv
// 27:1 datapath bus multiplexer with a registered bus snapshot and a
// sticky multi-driver fault flag.
module datapath_bus
  import bus_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              R0out,  R1out,  R2out,  R3out,
  input  logic              R4out,  R5out,  R6out,  R7out,
  input  logic              R8out,  R9out,  R10out, R11out,
  input  logic              R12out, R13out, R14out, R15out,
  input  logic              HIout, LOout, Zhighout, Zlowout, PCout, IRout,
  input  logic              MDRout, INout, Cout, Yout, MARout,
  input  logic [DATA_W-1:0] R0,  R1,  R2,  R3,  R4,  R5,  R6,  R7,
  input  logic [DATA_W-1:0] R8,  R9,  R10, R11, R12, R13, R14, R15,
  input  logic [DATA_W-1:0] HI, LO, ZHI, ZLO, PC, IR,
  input  logic [DATA_W-1:0] MDR, IN, CSIGN, Y, MAR,
  output logic [DATA_W-1:0] BusMuxOut,
  output logic [4:0]        bus_sel,
  output logic [DATA_W-1:0] bus_q,
  output logic              multi_drive
);

  logic [NUM_SRC-1:0] w_en;
  logic [DATA_W-1:0]  w_src [NUM_SRC];
  logic               w_multi;
  logic [DATA_W-1:0]  r_bus_q;
  logic               r_multi_drive;

  // Bit position of each enable equals its source index.
  assign w_en = {MARout, Yout, Cout, INout, MDRout, IRout, PCout, Zlowout,
                 Zhighout, LOout, HIout,
                 R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                 R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

  assign w_src = '{R0, R1, R2,  R3,  R4,  R5,  R6,  R7,
                   R8, R9, R10, R11, R12, R13, R14, R15,
                   HI, LO, ZHI, ZLO, PC, IR, MDR, IN, CSIGN, Y, MAR};

  bus_encoder_32to5 u_enc (
    .i_en    (w_en),
    .o_sel   (bus_sel),
    .o_multi (w_multi)
  );

  // Route the selected source onto the bus; an idle bus reads as zero.
  always_comb begin
    BusMuxOut = '0;
    if (bus_sel != SRC_NONE) BusMuxOut = w_src[bus_sel];
  end

  // Snapshot the bus and accumulate multi-driver faults until reset.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      r_bus_q       <= '0;
      r_multi_drive <= 1'b0;
    end else begin
      r_bus_q       <= BusMuxOut;
      r_multi_drive <= r_multi_drive | w_multi;
    end
  end

  assign bus_q       = r_bus_q;
  assign multi_drive = r_multi_drive;

endmodule

// File: tb/tb_datapath_bus.sv
// Self-checking bench for datapath_bus: directed cases plus random
// enables/data against a queue-based reference model.
module tb_datapath_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic [26:0] en;
  logic [31:0] src [27];
  logic [31:0] bus_out, bus_q;
  logic [4:0]  bus_sel;
  logic        multi_drive;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state for the registered outputs.
  logic [31:0] exp_q;
  logic        exp_multi;

  always #5 clk = ~clk;

  datapath_bus dut (
    .clk(clk), .reset(reset),
    .R0out(en[0]),   .R1out(en[1]),   .R2out(en[2]),   .R3out(en[3]),
    .R4out(en[4]),   .R5out(en[5]),   .R6out(en[6]),   .R7out(en[7]),
    .R8out(en[8]),   .R9out(en[9]),   .R10out(en[10]), .R11out(en[11]),
    .R12out(en[12]), .R13out(en[13]), .R14out(en[14]), .R15out(en[15]),
    .HIout(en[16]), .LOout(en[17]), .Zhighout(en[18]), .Zlowout(en[19]),
    .PCout(en[20]), .IRout(en[21]), .MDRout(en[22]), .INout(en[23]),
    .Cout(en[24]), .Yout(en[25]), .MARout(en[26]),
    .R0(src[0]),   .R1(src[1]),   .R2(src[2]),   .R3(src[3]),
    .R4(src[4]),   .R5(src[5]),   .R6(src[6]),   .R7(src[7]),
    .R8(src[8]),   .R9(src[9]),   .R10(src[10]), .R11(src[11]),
    .R12(src[12]), .R13(src[13]), .R14(src[14]), .R15(src[15]),
    .HI(src[16]), .LO(src[17]), .ZHI(src[18]), .ZLO(src[19]),
    .PC(src[20]), .IR(src[21]), .MDR(src[22]), .IN(src[23]),
    .CSIGN(src[24]), .Y(src[25]), .MAR(src[26]),
    .BusMuxOut(bus_out), .bus_sel(bus_sel), .bus_q(bus_q),
    .multi_drive(multi_drive)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Indices of every asserted enable, in ascending order.
  function automatic void active(input logic [26:0] e, output int q[$]);
    q = {};
    for (int i = 0; i < 27; i++) if (e[i]) q.push_back(i);
  endfunction

  function automatic logic [31:0] model_sel(input logic [26:0] e);
    int q[$];
    active(e, q);
    return (q.size() == 0) ? 32'd31 : 32'(q[0]);
  endfunction

  function automatic logic [31:0] model_bus(input logic [26:0] e);
    int q[$];
    active(e, q);
    return (q.size() == 0) ? 32'd0 : src[q[0]];
  endfunction

  function automatic int model_count(input logic [26:0] e);
    int q[$];
    active(e, q);
    return q.size();
  endfunction

  task automatic check_comb(input string tag);
    #1;
    check({tag, ".bus"}, bus_out, model_bus(en));
    check({tag, ".sel"}, {27'd0, bus_sel}, model_sel(en));
  endtask

  // Advance one edge, update the reference registers, and compare.
  task automatic tick(input string tag);
    logic [31:0] nq;
    logic        nm;
    nq = reset ? 32'd0 : model_bus(en);
    nm = reset ? 1'b0  : (exp_multi | (model_count(en) > 1));
    @(posedge clk);
    exp_q = nq;
    exp_multi = nm;
    #1;
    check({tag, ".q"}, bus_q, exp_q);
    check({tag, ".multi"}, {31'd0, multi_drive}, {31'd0, exp_multi});
  endtask

  initial begin
    reset = 1'b1;
    en = '0;
    for (int i = 0; i < 27; i++) src[i] = 32'(i);
    exp_q = '0;
    exp_multi = 1'b0;
    @(negedge clk);
    tick("reset");
    check("reset.q_zero", bus_q, 32'd0);
    reset = 1'b0;

    // Directed: MDR drives 64.
    src[18] = 32'd18; src[19] = 32'd19; src[22] = 32'd64;
    en = '0; en[22] = 1'b1;
    check_comb("mdr");
    check("mdr.bus_const", bus_out, 32'd64);
    check("mdr.sel_const", {27'd0, bus_sel}, 32'd22);
    tick("mdr");
    check("mdr.q_const", bus_q, 32'd64);

    // Idle bus.
    en = '0;
    check_comb("idle");
    check("idle.sel_const", {27'd0, bus_sel}, 32'd31);

    // Walk a single one across every source.
    for (int i = 0; i < 27; i++) src[i] = 32'hA500_0000 + 32'(i);
    for (int i = 0; i < 27; i++) begin
      en = '0; en[i] = 1'b1;
      check_comb($sformatf("walk%0d", i));
      check($sformatf("walk%0d.val", i), bus_out, 32'hA500_0000 + 32'(i));
    end
    tick("walk_end");

    // Two drivers: R4 and PC.
    for (int i = 0; i < 27; i++) src[i] = 32'(i);
    src[20] = 32'd18;
    en = '0; en[4] = 1'b1; en[20] = 1'b1;
    check_comb("dual");
    check("dual.bus_const", bus_out, 32'd4);
    tick("dual");
    check("dual.multi_set", {31'd0, multi_drive}, 32'd1);
    en[20] = 1'b0;
    tick("dual_drop");
    check("dual.multi_sticky", {31'd0, multi_drive}, 32'd1);
    reset = 1'b1;
    tick("dual_reset");
    check("dual.multi_clr", {31'd0, multi_drive}, 32'd0);
    reset = 1'b0;

    // Selected data changes propagate; unselected do not.
    src[22] = 32'd64;
    en = '0; en[22] = 1'b1;
    check_comb("mdr_a");
    src[22] = 32'h0000_0024;
    check_comb("mdr_b");
    check("mdr_b.val", bus_out, 32'h0000_0024);
    src[7] = 32'hDEAD_BEEF;
    check_comb("r7_unsel");
    check("r7_unsel.val", bus_out, 32'h0000_0024);
    tick("mdr_chg");

    // Reset does not touch the combinational path.
    en = '0; en[3] = 1'b1; src[3] = 32'd3;
    reset = 1'b1;
    check_comb("rst_r3");
    check("rst_r3.bus_const", bus_out, 32'd3);
    tick("rst_r3");
    check("rst_r3.q0", bus_q, 32'd0);
    reset = 1'b0;
    tick("rst_rel");
    check("rst_rel.q3", bus_q, 32'd3);

    // Random enables and data, occasional reset.
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 27; i++) src[i] = $urandom;
      case ($urandom_range(0, 3))
        0: en = '0;
        1: begin en = '0; en[$urandom_range(0, 26)] = 1'b1; end
        2: begin
             en = '0;
             en[$urandom_range(0, 26)] = 1'b1;
             en[$urandom_range(0, 26)] = 1'b1;
           end
        default: en = 27'($urandom);
      endcase
      reset = ($urandom_range(0, 19) == 0);
      check_comb($sformatf("rnd%0d", k));
      tick($sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
